// File: rtl/sdram_pkg.sv
// sdram_pkg: states, SDRAM command encodings and default timings.
// Shared by sdram_ctrl and sdram_refresh_timer (SDRAM_REFRESH_EN).
package sdram_pkg;

  typedef logic [3:0] state_t;

  localparam state_t S_IDLE = 4'd0;
  localparam state_t S_ACT  = 4'd1;
  localparam state_t S_RCD  = 4'd2;
  localparam state_t S_CMD  = 4'd3;
  localparam state_t S_DATA = 4'd4;
  localparam state_t S_PRE  = 4'd5;
  localparam state_t S_RP   = 4'd6;
  localparam state_t S_REF  = 4'd7;
  localparam state_t S_RFC  = 4'd8;

  // {CS, RAS, CAS, WE}, all active low
  typedef logic [3:0] cmd_t;

  localparam cmd_t C_DESEL = 4'b1111;
  localparam cmd_t C_NOP   = 4'b0111;
  localparam cmd_t C_ACT   = 4'b0011;
  localparam cmd_t C_READ  = 4'b0101;
  localparam cmd_t C_WRITE = 4'b0100;
  localparam cmd_t C_PRE   = 4'b0010;
  localparam cmd_t C_REF   = 4'b0001;

  localparam int DEF_BURST_LEN      = 8;
  localparam int DEF_TRCD           = 2;
  localparam int DEF_TRP            = 2;
  localparam int DEF_REFRESH_PERIOD = 512;
  localparam int DEF_TRFC           = 4;

endpackage

// File: rtl/sdram_refresh_timer.sv
// sdram_refresh_timer: free-running refresh interval counter.
// Raises a saturating pending flag; only built with SDRAM_REFRESH_EN.
module sdram_refresh_timer
  import sdram_pkg::*;
#(
  parameter int PERIOD = DEF_REFRESH_PERIOD
) (
  input  logic clock,
  input  logic reset,
  input  logic clr,
  output logic pending
);

  logic [31:0] cnt;
  logic        tick;

  assign tick = (cnt == 32'(PERIOD - 1));

  // count PERIOD clocks; a new tick never queues a second refresh
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt     <= '0;
      pending <= 1'b0;
    end else begin
      cnt     <= tick ? '0 : cnt + 32'd1;
      pending <= tick | (pending & ~clr);
    end
  end

endmodule

// File: rtl/sdram_ctrl.sv
// sdram_ctrl: single-burst SDRAM controller, registered outputs.
// Define SDRAM_REFRESH_EN to build in the auto-refresh timer.
module sdram_ctrl
  import sdram_pkg::*;
#(
  parameter int BURST_LEN      = DEF_BURST_LEN,
  parameter int TRCD           = DEF_TRCD,
  parameter int TRP            = DEF_TRP,
  parameter int REFRESH_PERIOD = DEF_REFRESH_PERIOD,
  parameter int TRFC           = DEF_TRFC
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req,
  input  logic        rw,
  input  logic [1:0]  bank,
  input  logic [9:0]  row,
  input  logic [31:0] wdata,
  output logic        ack,
  output logic        wnext,
  output logic [31:0] rdata,
  output logic        rvalid,
  output logic        done,
  output logic        busy,
  output logic [1:0]  BS,
  output logic [9:0]  A,
  output logic        bar_CS,
  output logic        bar_RAS,
  output logic        bar_CAS,
  output logic        bar_WE,
  output logic        EnWData,
  output logic        EnRData,
  output logic [31:0] WData,
  input  logic [31:0] RData
);

  if (BURST_LEN < 1 || BURST_LEN > 9) begin : g_bl_chk
    $error("sdram_ctrl: BURST_LEN must be 1..9");
  end

  if (TRCD < 1 || TRP < 1 || REFRESH_PERIOD < 1) begin : g_t_chk
    $error("sdram_ctrl: TRCD, TRP, REFRESH_PERIOD must be >= 1");
  end

  localparam logic [15:0] LAST_BEAT = 16'(BURST_LEN - 1);
  localparam logic [15:0] RCD_LAST  = 16'(TRCD - 2);
  localparam logic [15:0] RP_LAST   = 16'(TRP - 1);
  localparam logic [15:0] RFC_LAST  = 16'((TRFC > 0) ? TRFC - 1 : 0);

  state_t      state, nxt;
  logic [15:0] cnt, nxt_cnt;
  cmd_t        cmd_q, nxt_cmd;
  logic        rw_q;
  logic        ref_pend;

`ifdef SDRAM_REFRESH_EN
  logic ref_clr;

  assign ref_clr = (state == S_IDLE) && ref_pend;

  sdram_refresh_timer #(
    .PERIOD(REFRESH_PERIOD)
  ) u_rfsh (
    .clock  (clock),
    .reset  (reset),
    .clr    (ref_clr),
    .pending(ref_pend)
  );
`else
  assign ref_pend = 1'b0;
`endif

  assign {bar_CS, bar_RAS, bar_CAS, bar_WE} = cmd_q;

  // next state and phase counter
  always_comb begin
    nxt     = state;
    nxt_cnt = cnt;
    case (state)
      S_IDLE: begin
        if (ref_pend) nxt = S_REF;
        else if (req) nxt = S_ACT;
        nxt_cnt = '0;
      end
      S_ACT: begin
        nxt     = (TRCD > 1) ? S_RCD : S_CMD;
        nxt_cnt = '0;
      end
      S_RCD: begin
        if (cnt == RCD_LAST) nxt = S_CMD;
        else nxt_cnt = cnt + 16'd1;
      end
      S_CMD: begin
        nxt     = S_DATA;
        nxt_cnt = '0;
      end
      S_DATA: begin
        if (cnt == LAST_BEAT) nxt = S_PRE;
        else nxt_cnt = cnt + 16'd1;
      end
      S_PRE: begin
        nxt     = S_RP;
        nxt_cnt = '0;
      end
      S_RP: begin
        if (cnt == RP_LAST) begin
          nxt     = S_IDLE;
          nxt_cnt = '0;
        end else nxt_cnt = cnt + 16'd1;
      end
      S_REF: begin
        nxt     = S_RFC;
        nxt_cnt = '0;
      end
      S_RFC: begin
        if (cnt == RFC_LAST) begin
          nxt     = S_IDLE;
          nxt_cnt = '0;
        end else nxt_cnt = cnt + 16'd1;
      end
      default: begin
        nxt     = S_IDLE;
        nxt_cnt = '0;
      end
    endcase
  end

  // command for the cycle the next state occupies
  always_comb begin
    nxt_cmd = C_NOP;
    unique case (1'b1)
      nxt == S_IDLE: nxt_cmd = C_DESEL;
      nxt == S_ACT:  nxt_cmd = C_ACT;
      nxt == S_CMD:  nxt_cmd = rw_q ? C_WRITE : C_READ;
      nxt == S_PRE:  nxt_cmd = C_PRE;
      nxt == S_REF:  nxt_cmd = C_REF;
      default:       nxt_cmd = C_NOP;
    endcase
  end

  // state plus every output registered from the next state;
  // wnext leads each write beat by one cycle so WData lines up
  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= S_IDLE;
      cnt     <= '0;
      cmd_q   <= C_DESEL;
      rw_q    <= 1'b0;
      BS      <= '0;
      A       <= '0;
      WData   <= '0;
      EnWData <= 1'b0;
      EnRData <= 1'b0;
      ack     <= 1'b0;
      wnext   <= 1'b0;
      rvalid  <= 1'b0;
      rdata   <= '0;
      done    <= 1'b0;
      busy    <= 1'b0;
    end else begin
      state   <= nxt;
      cnt     <= nxt_cnt;
      cmd_q   <= nxt_cmd;
      if (nxt == S_ACT) begin
        rw_q <= rw;
        BS   <= bank;
      end
      A       <= (nxt == S_ACT) ? row : '0;
      if (wnext) WData <= wdata;
      EnWData <= (nxt == S_DATA) && rw_q;
      EnRData <= (nxt == S_DATA) && !rw_q;
      wnext   <= rw_q && ((nxt == S_CMD) ||
                 ((nxt == S_DATA) && (nxt_cnt != LAST_BEAT)));
      ack     <= (nxt == S_ACT);
      rvalid  <= EnRData;
      if (EnRData) rdata <= RData;
      done    <= (nxt == S_RP) && (nxt_cnt == RP_LAST);
      busy    <= (nxt != S_IDLE);
    end
  end

endmodule

// File: doc/sdram_ctrl.md
SDRAM_CTRL -- requirements
Module: sdram_ctrl

Interface
REQ-001 SHALL have parameter BURST_LEN, default 8: words per access, legal range 1..9.
REQ-002 SHALL have parameter TRCD, default 2: cycles from ACTIVE to READ/WRITE, minimum 1.
REQ-003 SHALL have parameter TRP, default 2: cycles from PRECHARGE to next command, minimum 1.
REQ-004 SHALL have parameter REFRESH_PERIOD, default 512: clocks between refresh requests.
REQ-005 SHALL have parameter TRFC, default 4: cycles after REFRESH before IDLE.
REQ-006 clock  in  1  sole clock, rising edge.
REQ-007 reset  in  1  synchronous, active-high reset.
REQ-008 req  in  1  host access request, held until ack.
REQ-009 rw  in  1  1 = write burst, 0 = read burst; sampled with req.
REQ-010 bank  in  2  target bank; sampled with req.
REQ-011 row  in  10  target row; sampled with req.
REQ-012 wdata  in  32  host write word, consumed when wnext=1.
REQ-013 ack  out  1  one-cycle pulse: request accepted.
REQ-014 wnext  out  1  current wdata is taken this cycle.
REQ-015 rdata  out  32  read word, valid when rvalid=1.
REQ-016 rvalid  out  1  rdata valid.
REQ-017 done  out  1  one-cycle pulse: burst complete, precharge elapsed.
REQ-018 busy  out  1  state is not IDLE.
REQ-019 BS  out  2, A  out  10, bar_CS/bar_RAS/bar_CAS/bar_WE  out  1 each: SDRAM command/address.
REQ-020 EnWData  out  1, EnRData  out  1, WData  out  32: SDRAM data strobes and write data.
REQ-021 RData  in  32  SDRAM read data, registered one cycle after EnRData.

Function
REQ-022 Commands {CS,RAS,CAS,WE} SHALL be: DESELECT 1xxx, NOP 0111, ACTIVE 0011, READ 0101, WRITE 0100, PRECHARGE 0010, REFRESH 0001.
REQ-023 States: IDLE, ACT, RCD, CMD, DATA, PRE, RP, REF, RFC; all outputs registered.
REQ-024 IDLE: on req=1, latch rw/bank/row; go to ACT; next cycle ack=1 and ACTIVE issued with BS=bank, A=row.
REQ-025 RCD: NOP for TRCD-1 cycles (0 when TRCD=1); then CMD issues READ or WRITE with A=0, BS held.
REQ-026 DATA: exactly BURST_LEN consecutive cycles with EnWData (write) or EnRData (read) high; never both high.
REQ-027 Write DATA: wnext=1 and WData=wdata each cycle; host supplies a new word every cycle, no backpressure.
REQ-028 Read: rvalid=1 and rdata=RData in each cycle following an EnRData cycle; last beat coincides with PRE.
REQ-029 PRE: PRECHARGE one cycle, EnWData/EnRData low (resets SDRAM word counter); RP: NOP TRP cycles; done=1 on last RP cycle; then IDLE.
REQ-030 EnWData/EnRData SHALL be low in every state except DATA.
REQ-031 Host-visible latency req-sample to first data beat = 2+TRCD cycles; total occupancy = 3+TRCD+BURST_LEN+TRP cycles.
REQ-032 req while busy SHALL be ignored; ack only from IDLE; back-to-back requests separated by at least one IDLE cycle.
REQ-033 BURST_LEN outside 1..9 SHALL be a elaboration-time error.

Reset
REQ-034 reset SHALL force IDLE and counters to 0 on the next edge, including mid-burst.
REQ-035 Reset values: bar_CS=1, bar_RAS=bar_CAS=bar_WE=1, BS=0, A=0, WData=0, EnWData=EnRData=0, ack=wnext=rvalid=done=busy=0, rdata=0.

Configuration
REQ-036 Macro SDRAM_REFRESH_EN SHALL enable auto-refresh.
REQ-037 With it: counter sets refresh_pending every REFRESH_PERIOD clocks; IDLE services pending before req (REF: REFRESH one cycle, RFC: NOP TRFC cycles, clear pending); refresh during burst deferred to next IDLE; pending saturates, never queues twice.
REQ-038 Without it: no counter, REF/RFC unreachable, REFRESH never issued.

Structure
REQ-039 Package sdram_pkg SHALL hold state enum, command encodings, default timing constants.
REQ-040 Sub-module sdram_refresh_timer SHALL implement the refresh counter/pending flag, instantiated only under SDRAM_REFRESH_EN.

Verification
REQ-041 Write rw=1 bank=2 row=5, wdata 0x1..0x8 -> ACTIVE cycle 1, WRITE cycle 3, EnWData cycles 4..11, PRECHARGE 12, done cycle 14.
REQ-042 Read back bank 2 -> rvalid cycles 5..12, rdata 0x1..0x8 in order.
REQ-043 reset at 3rd DATA beat -> next cycle EnWData=0, bar_CS=1, busy=0; new request completes normally.
REQ-044 req held during burst -> single ack; second ack only after done and one IDLE cycle.
REQ-045 SDRAM_REFRESH_EN, REFRESH_PERIOD=16, req at refresh expiry -> REFRESH issued first, ACTIVE after TRFC.
REQ-046 BURST_LEN=1, TRCD=1, TRP=1 -> one data beat, occupancy 6 cycles.
